tile_reader: RTL and testbench

Read-back engine for the 160x120, 3-bit-colour framebuffer that the square plotter writes. On a start request it reads the 4x4 tile at a given base coordinate, one pixel per cycle, through the framebuffer's synchronous read port. It reports how many pixels match a key colour and whether the tile is a single colour, then pulses `done`. It lets the team verify plotted squares on-chip and drives later collision and pick logic.

---
 rtl/fb_pkg.sv | 28 ++
 rtl/tile_addr_counter.sv | 28 ++
 rtl/tile_reader.sv | 144 ++++++++++++++
 tb/tb_tile_reader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, tile constants and tile_reader state encoding.
package fb_pkg;

  localparam int unsigned X_W = 8;
  localparam int unsigned Y_W = 7;
  localparam int unsigned C_W = 3;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam int unsigned TILE_DIM    = 4;
  localparam int unsigned TILE_PIXELS = TILE_DIM * TILE_DIM;
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned CNT_W       = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StRead  = ST_READ,
    StDrain = ST_DRAIN,
    StDone  = ST_DONE
  } state_e;

endpackage

// File: rtl/tile_addr_counter.sv
// Pixel index within a 4x4 tile; x varies in idx[1:0], y in idx[3:2].
module tile_addr_counter
  import fb_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
    end else if (clear) begin
      idx_q <= '0;
    end else if (enable) begin
      idx_q <= idx_q + IDX_W'(1);
    end
  end

  assign idx  = idx_q;
  assign last = (idx_q == IDX_W'(TILE_PIXELS - 1));

endmodule

// File: rtl/tile_reader.sv
// Reads a 4x4 framebuffer tile, counts key-colour matches and detects uniformity.
// Optional per-colour histogram enabled by defining TILE_READER_HIST_EN.
module tile_reader #(
  parameter int unsigned X_W = fb_pkg::X_W,
  parameter int unsigned Y_W = fb_pkg::Y_W,
  parameter int unsigned C_W = fb_pkg::C_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [X_W-1:0]         x_base,
  input  logic [Y_W-1:0]         y_base,
  input  logic [C_W-1:0]         key_colour,
  output logic                   rd_en,
  output logic [X_W-1:0]         rd_x,
  output logic [Y_W-1:0]         rd_y,
  input  logic [C_W-1:0]         rd_data,
  output logic                   busy,
  output logic                   done,
  output logic [fb_pkg::CNT_W-1:0] match_count,
  output logic                   uniform
`ifdef TILE_READER_HIST_EN
  ,
  input  logic [C_W-1:0]         hist_sel,
  output logic [fb_pkg::CNT_W-1:0] hist_count
`endif
);

  import fb_pkg::*;

  state_e           state_q, state_d;
  logic             accept, cnt_en, last;
  logic [IDX_W-1:0] idx;

  logic [X_W-1:0]   base_x_q;
  logic [Y_W-1:0]   base_y_q;
  logic [C_W-1:0]   key_q, ref_q;
  logic             ref_valid_q, valid_q, uniform_q;
  logic [CNT_W-1:0] match_q;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRead;
          accept  = 1'b1;
        end
      end
      StRead: begin
        if (last) state_d = StDrain;
        else      cnt_en  = 1'b1;
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // idx stays at 15 after the last issue so rd_x/rd_y hold outside READ.
  tile_addr_counter u_idx (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept),
    .enable (cnt_en),
    .idx    (idx),
    .last   (last)
  );

  assign rd_en = (state_q == StRead);
  assign rd_x  = base_x_q + {{(X_W-2){1'b0}}, idx[1:0]};
  assign rd_y  = base_y_q + {{(Y_W-2){1'b0}}, idx[3:2]};
  assign busy  = (state_q != StIdle);
  assign done  = (state_q == StDone);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_x_q <= '0;
      base_y_q <= '0;
      key_q    <= '0;
    end else if (accept) begin
      base_x_q <= x_base;
      base_y_q <= y_base;
      key_q    <= key_colour;
    end
  end

  // Read data returns one cycle after the strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= rd_en;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      match_q     <= '0;
      uniform_q   <= 1'b0;
      ref_q       <= '0;
      ref_valid_q <= 1'b0;
    end else if (accept) begin
      match_q     <= '0;
      uniform_q   <= 1'b1;
      ref_q       <= '0;
      ref_valid_q <= 1'b0;
    end else if (valid_q) begin
      if (rd_data == key_q) match_q <= match_q + CNT_W'(1);
      if (!ref_valid_q) begin
        ref_q       <= rd_data;
        ref_valid_q <= 1'b1;
      end else if (rd_data != ref_q) begin
        uniform_q <= 1'b0;
      end
    end
  end

  assign match_count = match_q;
  assign uniform     = uniform_q;

`ifdef TILE_READER_HIST_EN
  localparam int unsigned NBINS = 1 << C_W;

  logic [CNT_W-1:0] bins_q [NBINS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NBINS; i++) bins_q[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NBINS; i++) bins_q[i] <= '0;
    end else if (valid_q) begin
      bins_q[rd_data] <= bins_q[rd_data] + CNT_W'(1);
    end
  end

  assign hist_count = bins_q[hist_sel];
`endif

endmodule

// File: tb/tb_tile_reader.sv
// Randomized bench for tile_reader against a framebuffer array and tile-level reference model.
module tb_tile_reader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x_base = '0;
  logic [6:0] y_base = '0;
  logic [2:0] key_colour = '0;
  logic       rd_en;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  logic [2:0] rd_data = '0;
  logic       busy, done, uniform;
  logic [4:0] match_count;
`ifdef TILE_READER_HIST_EN
  logic [2:0] hist_sel = '0;
  logic [4:0] hist_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [2:0] fb [0:255][0:127];
  int         exp_match_g;
  bit         exp_uni_g;
  int         exp_hist_g [8];

  always #5 clock = ~clock;

  tile_reader dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .x_base      (x_base),
    .y_base      (y_base),
    .key_colour  (key_colour),
    .rd_en       (rd_en),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_data     (rd_data),
    .busy        (busy),
    .done        (done),
    .match_count (match_count),
    .uniform     (uniform)
`ifdef TILE_READER_HIST_EN
    ,
    .hist_sel    (hist_sel),
    .hist_count  (hist_count)
`endif
  );

  // Framebuffer synchronous read port.
  always @(posedge clock) begin
    if (rd_en) rd_data <= fb[rd_x][rd_y];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic paint(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] col);
    logic [7:0] px;
    logic [6:0] py;
    for (int i = 0; i < 16; i++) begin
      px = bx + 8'(i % 4);
      py = by + 7'(i / 4);
      fb[px][py] = col;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_x"}, rd_x, 0);
    check({tag, "_rd_y"}, rd_y, 0);
    check({tag, "_match"}, match_count, 0);
    check({tag, "_uniform"}, uniform, 0);
`ifdef TILE_READER_HIST_EN
    check({tag, "_hist"}, hist_count, 0);
`endif
  endtask

  // Call at posedge+1 with the DUT idle; returns at posedge+1 of cycle 19.
  task automatic run_tile(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] key,
                          input bit noise, input string tag);
    logic [2:0] first, px;
    logic [7:0] ex;
    logic [6:0] ey;
    exp_match_g = 0;
    exp_uni_g   = 1'b1;
    for (int k = 0; k < 8; k++) exp_hist_g[k] = 0;
    first = fb[bx][by];
    for (int i = 0; i < 16; i++) begin
      px = fb[bx + 8'(i % 4)][by + 7'(i / 4)];
      if (px == key)   exp_match_g++;
      if (px != first) exp_uni_g = 1'b0;
      exp_hist_g[px]++;
    end

    x_base = bx; y_base = by; key_colour = key; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      if (noise && c < 18) begin
        start      = 1'($urandom_range(0, 1));
        key_colour = 3'($urandom);
        x_base     = 8'($urandom);
        y_base     = 7'($urandom);
      end
      if (c == 18) start = 1'b0;
      @(negedge clock);
      check($sformatf("%s_rd_en_c%0d", tag, c), rd_en, (c <= 16));
      if (c <= 16) begin
        ex = bx + 8'((c - 1) % 4);
        ey = by + 7'((c - 1) / 4);
        check($sformatf("%s_rd_x_c%0d", tag, c), rd_x, ex);
        check($sformatf("%s_rd_y_c%0d", tag, c), rd_y, ey);
      end
      check($sformatf("%s_done_c%0d", tag, c), done, (c == 18));
      check($sformatf("%s_busy_c%0d", tag, c), busy, 1);
      if (c == 18) begin
        check({tag, "_match"}, match_count, exp_match_g);
        check({tag, "_uniform"}, uniform, exp_uni_g);
      end
      @(posedge clock); #1;
    end
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  task automatic check_hold_and_hist(input string tag);
`ifdef TILE_READER_HIST_EN
    int sum;
`endif
    repeat (3) @(posedge clock);
    #1;
    check({tag, "_hold_match"}, match_count, exp_match_g);
    check({tag, "_hold_uniform"}, uniform, exp_uni_g);
`ifdef TILE_READER_HIST_EN
    sum = 0;
    for (int s = 0; s < 8; s++) begin
      hist_sel = 3'(s);
      #1;
      check($sformatf("%s_hist%0d", tag, s), hist_count, exp_hist_g[s]);
      sum += int'(hist_count);
    end
    check({tag, "_hist_sum"}, sum, 16);
`endif
    @(posedge clock); #1;
  endtask

  initial begin
    int   dpos[$];
    int   done_seen;
    logic [7:0] bx;
    logic [6:0] by;

    for (int x = 0; x < 256; x++)
      for (int y = 0; y < 128; y++)
        fb[x][y] = 3'($urandom_range(0, 7));

    repeat (2) @(posedge clock);
    #1;
    check_outputs_zero("reset");
    reset = 1'b0;
    @(posedge clock); #1;

    // Uniform tile, key matches everything.
    paint(8'd10, 7'd20, 3'd3);
    run_tile(8'd10, 7'd20, 3'd3, 1'b0, "solid");
    check("solid_const_match", match_count, 16);
    check("solid_const_uniform", uniform, 1);
    check_hold_and_hist("solid");

    // One odd pixel.
    fb[12][21] = 3'd5;
    run_tile(8'd10, 7'd20, 3'd5, 1'b0, "odd");
    check("odd_const_match", match_count, 1);
    check("odd_const_uniform", uniform, 0);
    check_hold_and_hist("odd");

    // Coordinate wrap at both axes.
    run_tile(8'd254, 7'd126, 3'($urandom), 1'b0, "wrap");
    check_hold_and_hist("wrap");

    // Reset partway through a read.
    x_base = 8'd40; y_base = 7'd50; key_colour = 3'd1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (6) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("midreset");
    @(posedge clock); #1;
    reset = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clock);
      if (done || busy) done_seen++;
    end
    check("midreset_quiet", done_seen, 0);
    @(posedge clock); #1;
    run_tile(8'd40, 7'd50, 3'd1, 1'b0, "after_reset");

    // Random tiles with start/key/base noise while busy.
    for (int t = 0; t < 8; t++) begin
      bx = 8'($urandom);
      by = 7'($urandom);
      if ($urandom_range(0, 2) == 0) paint(bx, by, 3'($urandom));
      run_tile(bx, by, 3'($urandom), 1'b1, $sformatf("rnd%0d", t));
      if (t % 3 == 0) check_hold_and_hist($sformatf("rnd%0d", t));
    end

    // start held high: back-to-back tiles every 19 cycles.
    x_base = 8'd100; y_base = 7'd60; key_colour = 3'd2; start = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(negedge clock);
      if (done) dpos.push_back(c);
      @(posedge clock); #1;
    end
    start = 1'b0;
    check("held_pulses", dpos.size(), 3);
    if (dpos.size() >= 3) begin
      check("held_first", dpos[0], 18);
      check("held_gap0", dpos[1] - dpos[0], 19);
      check("held_gap1", dpos[2] - dpos[1], 19);
    end
    done_seen = 0;
    for (int c = 0; c < 40 && busy; c++) begin
      @(posedge clock); #1;
      done_seen++;
    end
    check("held_drain_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
